// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: sequences operand entry, launches the ALU,
// supervises completion with a timeout and drives the display/error outputs.
module calc_entry_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_OPERAND    = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_clr,
  input  logic [1:0]  op_sel,
  input  logic [13:0] number_1,
  input  logic [13:0] number_2,
  input  logic        alu_done,
  input  logic        alu_err,
  input  logic [27:0] alu_result,
  output logic        write_number_select,
  output logic        clr_numbers,
  output logic        alu_start,
  output logic [13:0] alu_a,
  output logic [13:0] alu_b,
  output logic [1:0]  alu_op,
  output logic [27:0] display_value,
  output logic        display_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } state_t;

  // Counter is wide enough to hold TIMEOUT_CYCLES itself so it can saturate there.
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_SAT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [13:0]      MAX_OP   = 14'(MAX_OPERAND);

  state_t           state_r;
  logic [CNT_W-1:0] tmo_cnt_r;
  logic             wsel_r;
  logic             clr_numbers_r;
  logic             alu_start_r;
  logic [13:0]      alu_a_r;
  logic [13:0]      alu_b_r;
  logic [1:0]       alu_op_r;
  logic [27:0]      display_r;
  logic             display_err_r;
  logic             rst_d_r;
  logic             overrange_s;
  logic             clr_req_s;

  // Operand range check and the set of events that request a datapath clear.
  always_comb begin
    overrange_s = (number_1 > MAX_OP) || (number_2 > MAX_OP);
    clr_req_s   = rst_d_r || btn_clr ||
                  (btn_next && ((state_r == SHOW) || (state_r == ERR)));
  end

  // Main controller: state, latched operands, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ENTER_A;
      tmo_cnt_r     <= '0;
      wsel_r        <= 1'b0;
      clr_numbers_r <= 1'b0;
      alu_start_r   <= 1'b0;
      alu_a_r       <= 14'd0;
      alu_b_r       <= 14'd0;
      alu_op_r      <= 2'd0;
      display_r     <= 28'd0;
      display_err_r <= 1'b0;
      rst_d_r       <= 1'b1;
    end else begin
      rst_d_r       <= 1'b0;
      alu_start_r   <= 1'b0;
      // A clear request right after a clear pulse is dropped so the pulse never stretches.
      clr_numbers_r <= clr_req_s && !clr_numbers_r;
      if (btn_clr) begin
        state_r       <= ENTER_A;
        tmo_cnt_r     <= '0;
        wsel_r        <= 1'b0;
        alu_a_r       <= 14'd0;
        alu_b_r       <= 14'd0;
        alu_op_r      <= 2'd0;
        display_r     <= 28'd0;
        display_err_r <= 1'b0;
      end else begin
        case (state_r)
          ENTER_A: begin
            if (btn_next) begin
              state_r <= ENTER_B;
              wsel_r  <= 1'b1;
            end
          end
          ENTER_B: begin
            if (btn_next) begin
              wsel_r   <= 1'b0;
              alu_a_r  <= number_1;
              alu_b_r  <= number_2;
              alu_op_r <= op_sel;
              if (overrange_s) begin
                state_r       <= ERR;
                display_err_r <= 1'b1;
              end else begin
                state_r     <= START;
                alu_start_r <= 1'b1;
              end
            end
          end
          START: begin
            tmo_cnt_r <= '0;
            state_r   <= WAIT;
          end
          WAIT: begin
            // A completion on the final counted cycle still wins over the timeout.
            if (alu_done) begin
              if (alu_err) begin
                state_r       <= ERR;
                display_err_r <= 1'b1;
              end else begin
                state_r   <= SHOW;
                display_r <= alu_result;
              end
            end else if (tmo_cnt_r >= TMO_LAST) begin
              tmo_cnt_r     <= TMO_SAT;
              state_r       <= ERR;
              display_err_r <= 1'b1;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
            end
          end
          SHOW: begin
            if (btn_next) begin
              state_r   <= ENTER_A;
              display_r <= 28'd0;
            end
          end
          ERR: begin
            if (btn_next) begin
              state_r       <= ENTER_A;
              display_err_r <= 1'b0;
            end
          end
          default: begin
            state_r       <= ENTER_A;
            wsel_r        <= 1'b0;
            display_r     <= 28'd0;
            display_err_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Display follows the sliders live while entering, otherwise the latched value.
  always_comb begin
    display_value = display_r;
    case (state_r)
      ENTER_A: display_value = {14'd0, number_1};
      ENTER_B: display_value = {14'd0, number_2};
      default: display_value = display_r;
    endcase
  end

  assign write_number_select = wsel_r;
  assign clr_numbers         = clr_numbers_r;
  assign alu_start           = alu_start_r;
  assign alu_a               = alu_a_r;
  assign alu_b               = alu_b_r;
  assign alu_op              = alu_op_r;
  assign display_err         = display_err_r;
  assign state               = state_r;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Self-checking bench for calc_entry_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_calc_entry_ctrl;

  localparam int TMO   = 8;
  localparam int MAXOP = 9999;

  logic        clk;
  logic        rst;
  logic        btn_next;
  logic        btn_clr;
  logic [1:0]  op_sel;
  logic [13:0] number_1;
  logic [13:0] number_2;
  logic        alu_done;
  logic        alu_err;
  logic [27:0] alu_result;
  logic        write_number_select;
  logic        clr_numbers;
  logic        alu_start;
  logic [13:0] alu_a;
  logic [13:0] alu_b;
  logic [1:0]  alu_op;
  logic [27:0] display_value;
  logic        display_err;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Behavioural model of what the outputs must be.
  int          m_state;
  bit          m_wsel, m_start, m_clr, m_err, m_rstp;
  int          m_a, m_b, m_op, m_cnt;
  logic [27:0] m_disp;

  calc_entry_ctrl #(.TIMEOUT_CYCLES(TMO), .MAX_OPERAND(MAXOP)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_clr(btn_clr),
    .op_sel(op_sel), .number_1(number_1), .number_2(number_2),
    .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result),
    .write_number_select(write_number_select), .clr_numbers(clr_numbers),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .display_value(display_value), .display_err(display_err), .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, from the rules of the entry sequence.
  task automatic model_step();
    bit want_clr;
    if (rst) begin
      m_state = 0; m_wsel = 0; m_start = 0; m_err = 0; m_clr = 0;
      m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_disp = 28'd0; m_rstp = 1;
    end else begin
      want_clr = m_rstp || btn_clr || (btn_next && (m_state == 4 || m_state == 5));
      m_clr   = want_clr && !m_clr;
      m_rstp  = 0;
      m_start = 0;
      if (btn_clr) begin
        m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0;
      end else begin
        case (m_state)
          0: if (btn_next) m_state = 1;
          1: if (btn_next) begin
               m_a = number_1; m_b = number_2; m_op = op_sel;
               if (m_a > MAXOP || m_b > MAXOP) m_state = 5;
               else begin m_state = 2; m_start = 1; end
             end
          2: begin m_state = 3; m_cnt = 0; end
          3: if (alu_done) begin
               if (alu_err) m_state = 5;
               else begin m_state = 4; m_disp = alu_result; end
             end else begin
               m_cnt++;
               if (m_cnt >= TMO) m_state = 5;
             end
          default: if (btn_next) m_state = 0;
        endcase
      end
      if (m_state != 4) m_disp = 28'd0;
      m_wsel = (m_state == 1);
      m_err  = (m_state == 5);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    logic [27:0] exp_disp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_disp = (m_state == 0) ? {14'd0, number_1} :
                   (m_state == 1) ? {14'd0, number_2} : m_disp;
        chk("state", 32'(state), 32'(m_state));
        chk("write_number_select", 32'(write_number_select), 32'(m_wsel));
        chk("alu_start", 32'(alu_start), 32'(m_start));
        chk("clr_numbers", 32'(clr_numbers), 32'(m_clr));
        chk("display_err", 32'(display_err), 32'(m_err));
        chk("alu_a", 32'(alu_a), 32'(m_a));
        chk("alu_b", 32'(alu_b), 32'(m_b));
        chk("alu_op", 32'(alu_op), 32'(m_op));
        chk("display_value", 32'(display_value), 32'(exp_disp));
      end
    end
  end

  // Apply one cycle of inputs, let the edge happen, then release the pulses.
  task automatic cyc(input bit nx, input bit cl, input bit dn, input bit de, input logic [27:0] r);
    btn_next = nx; btn_clr = cl; alu_done = dn; alu_err = de; alu_result = r;
    @(posedge clk);
    #1;
    btn_next = 1'b0; btn_clr = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
  endtask

  function automatic logic [13:0] pick_num();
    case ($urandom_range(0, 7))
      0: return 14'd0;
      1: return 14'd9999;
      2: return 14'd10000;
      3: return 14'd16383;
      default: return 14'($urandom_range(0, 9999));
    endcase
  endfunction

  initial begin
    rst = 1'b1; btn_next = 1'b0; btn_clr = 1'b0; op_sel = 2'd0;
    number_1 = 14'd0; number_2 = 14'd0; alu_done = 1'b0; alu_err = 1'b0;
    alu_result = 28'd0;

    // Reset state
    cyc(0, 0, 0, 0, 28'd0);
    chk_en = 1;
    cyc(1, 1, 1, 0, 28'd5);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_clr", 32'(clr_numbers), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 28'd0);
    chk("post_rst_clr", 32'(clr_numbers), 32'd1);
    cyc(0, 0, 0, 0, 28'd0);
    chk("post_rst_clr_drop", 32'(clr_numbers), 32'd0);

    // Add sequence
    number_1 = 14'd12; number_2 = 14'd30; op_sel = 2'd0;
    cyc(1, 0, 0, 0, 28'd0);
    chk("add_enter_b", 32'(state), 32'd1);
    chk("add_disp_b", 32'(display_value), 32'd30);
    cyc(1, 0, 0, 0, 28'd0);
    chk("add_start", 32'(alu_start), 32'd1);
    chk("add_alu_a", 32'(alu_a), 32'd12);
    chk("add_alu_b", 32'(alu_b), 32'd30);
    cyc(0, 0, 0, 0, 28'd0);
    chk("add_wait", 32'(state), 32'd3);
    cyc(0, 0, 1, 0, 28'd42);
    chk("add_show", 32'(state), 32'd4);
    chk("add_result", 32'(display_value), 32'd42);
    cyc(1, 0, 0, 0, 28'd0);
    chk("show_next_clr", 32'(clr_numbers), 32'd1);
    chk("show_next_state", 32'(state), 32'd0);
    chk("show_next_wsel", 32'(write_number_select), 32'd0);

    // Overrange operand
    number_2 = 14'd10000;
    cyc(1, 0, 0, 0, 28'd0);
    cyc(1, 0, 0, 0, 28'd0);
    chk("ovr_state", 32'(state), 32'd5);
    chk("ovr_err", 32'(display_err), 32'd1);
    chk("ovr_no_start", 32'(alu_start), 32'd0);
    cyc(1, 0, 0, 0, 28'd0);
    number_2 = 14'd30;

    // Timeout: ERR exactly TMO cycles after entering WAIT
    cyc(1, 0, 0, 0, 28'd0);
    cyc(1, 0, 0, 0, 28'd0);
    cyc(0, 0, 0, 0, 28'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 28'd0);
    chk("tmo_still_wait", 32'(state), 32'd3);
    cyc(0, 0, 0, 0, 28'd0);
    chk("tmo_err", 32'(state), 32'd5);
    cyc(0, 1, 0, 0, 28'd0);

    // Done on the final cycle wins
    cyc(1, 0, 0, 0, 28'd0);
    cyc(1, 0, 0, 0, 28'd0);
    cyc(0, 0, 0, 0, 28'd0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 28'd0);
    cyc(0, 0, 1, 0, 28'd7);
    chk("tmo_edge_show", 32'(state), 32'd4);
    chk("tmo_edge_disp", 32'(display_value), 32'd7);
    cyc(1, 0, 0, 0, 28'd0);

    // Abort in WAIT
    op_sel = 2'd3;
    cyc(1, 0, 0, 0, 28'd0);
    cyc(1, 0, 0, 0, 28'd0);
    cyc(0, 0, 0, 0, 28'd0);
    cyc(0, 1, 0, 0, 28'd0);
    chk("abort_clr", 32'(clr_numbers), 32'd1);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    chk("abort_alu_op", 32'(alu_op), 32'd0);
    cyc(0, 0, 1, 0, 28'd99);
    chk("abort_done_ignored", 32'(state), 32'd0);

    // Simultaneous clear and next in ENTER_B
    cyc(1, 0, 0, 0, 28'd0);
    cyc(1, 1, 0, 0, 28'd0);
    chk("sim_state", 32'(state), 32'd0);
    chk("sim_alu_a", 32'(alu_a), 32'd0);
    chk("sim_no_start", 32'(alu_start), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 2) == 0) number_1 = pick_num();
      if ($urandom_range(0, 2) == 0) number_2 = pick_num();
      op_sel = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 28'($urandom));
    end
    rst = 1'b0;
    cyc(0, 0, 0, 0, 28'd0);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
CALC_ENTRY_CTRL -- requirements
Module: calc_entry_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024; maximum cycles to wait for alu_done before declaring an error.
REQ-002 Parameter MAX_OPERAND, default 9999; largest legal operand value.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 btn_next  in  1  debounced single-cycle pulse; advances entry sequence.
REQ-006 btn_clr  in  1  debounced single-cycle pulse; aborts and clears.
REQ-007 op_sel  in  2  operation select (00 add, 01 sub, 10 mul, 11 div).
REQ-008 number_1, number_2  in  14 each  operand values from slider-increment datapath.
REQ-009 alu_done  in  1  single-cycle ALU completion pulse.
REQ-010 alu_err  in  1  ALU error flag, valid with alu_done.
REQ-011 alu_result  in  28  ALU result, valid with alu_done.
REQ-012 write_number_select  out  1  0 = sliders edit number_1, 1 = sliders edit number_2.
REQ-013 clr_numbers  out  1  single-cycle pulse clearing datapath operands.
REQ-014 alu_start  out  1  single-cycle ALU launch pulse.
REQ-015 alu_a, alu_b  out  14 each  latched operands; alu_op  out  2  latched op_sel.
REQ-016 display_value  out  28  value for the display driver.
REQ-017 display_err  out  1  error indicator; state  out  3  current FSM state encoding.

Function
REQ-018 The FSM SHALL have states ENTER_A=0, ENTER_B=1, START=2, WAIT=3, SHOW=4, ERR=5. Encodings 6 and 7 SHALL go to ENTER_A on the next cycle.
REQ-019 ENTER_A transitions:
- write_number_select=0; display_value = zero-extended number_1, live.
- On btn_next: go to ENTER_B.
REQ-020 ENTER_B transitions:
- write_number_select=1; display_value = zero-extended number_2, live.
- On btn_next: latch alu_a=number_1, alu_b=number_2, alu_op=op_sel.
- Then go to START, or to ERR if either operand > MAX_OPERAND.
REQ-021 START SHALL assert alu_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-022 WAIT behaviour:
- Count cycles.
- On alu_done with alu_err=0: latch display_value=alu_result and go to SHOW.
- On alu_done with alu_err=1: go to ERR.
- If the count reaches TIMEOUT_CYCLES with no alu_done: go to ERR.
- alu_done on the same cycle the count reaches TIMEOUT_CYCLES counts as done.
REQ-023 btn_next ignored in START and WAIT; alu_done ignored in every state except WAIT.
REQ-024 SHOW holds display_value; ERR holds display_err=1 and display_value=0.
- In either state, btn_next pulses clr_numbers for one cycle and goes to ENTER_A.
REQ-025 btn_clr behaviour:
- Effective in any state, including WAIT mid-operation.
- Pulses clr_numbers for one cycle and goes to ENTER_A.
- Clears display_err and the latched alu_a, alu_b and alu_op.
- Suppresses alu_start.
REQ-026 btn_clr and btn_next in the same cycle: btn_clr SHALL win.
REQ-027 The timeout counter SHALL saturate and never wrap; width is ceil(log2(TIMEOUT_CYCLES+1)).
REQ-028 alu_start and clr_numbers SHALL never be high for two consecutive cycles.
REQ-029 All outputs SHALL be registered except display_value in ENTER_A and ENTER_B, which is combinational from the number inputs.

Reset
REQ-030 rst SHALL force the following on the next edge:
- state=ENTER_A.
- write_number_select=0, alu_start=0, display_err=0.
- alu_a=0, alu_b=0, alu_op=0, timeout counter=0.
REQ-031 rst SHALL pulse clr_numbers for one cycle on the first cycle after rst deasserts.
REQ-032 rst SHALL take priority over btn_clr, btn_next and alu_done.

Verification
REQ-033 Add sequence:
- number_1=12, number_2=30, op_sel=00; btn_next, btn_next.
- Expect: alu_start one cycle after the second pulse, alu_a=12, alu_b=30, alu_op=00.
- alu_done with alu_result=42: state=SHOW, display_value=42.
REQ-034 Overrange operand: number_2=10000, then btn_next in ENTER_B -> state=ERR, display_err=1, no alu_start.
REQ-035 ALU timeout:
- TIMEOUT_CYCLES=8, alu_done never asserted -> state=ERR exactly 8 cycles after entering WAIT.
- alu_done on cycle 8 -> state=SHOW.
REQ-036 Abort in WAIT: btn_clr -> clr_numbers one cycle, state=ENTER_A, alu_a=0; a later alu_done SHALL be ignored.
REQ-037 Simultaneous btn_clr and btn_next in ENTER_B -> state=ENTER_A, no operand latch, no alu_start.
REQ-038 SHOW then btn_next -> clr_numbers one cycle, state=ENTER_A, write_number_select=0.
